// File: rtl/instruction_prefetch_memory.sv
// Instruction memory with a sequential prefetcher feeding a small ready/valid FIFO.
// Program words are loaded through the write port; redirect flushes and restarts fetch.
module instruction_prefetch_memory #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          fetch_en,
  input  logic                          redirect,
  input  logic [ADDR_WIDTH-1:0]         redirect_pc,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [DATA_WIDTH-1:0]         instruction,
  output logic [ADDR_WIDTH-1:0]         instr_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned MemSz = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ResetPc   = ADDR_WIDTH'(RESET_PC);
  localparam logic [CntW:0]         DepthOcc  = (CntW + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MemSz];

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] rd_pc_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  inflight_q;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PtrW-1:0]       wptr_q;
  logic [PtrW-1:0]       rptr_q;
  logic [CntW-1:0]       count_q;

  logic          pop;
  logic          push;
  logic          issue;
  logic [CntW:0] occupancy;

  always_comb begin
    instr_valid = (count_q != '0);
    instruction = instr_valid ? fifo_data[rptr_q] : '0;
    instr_pc    = instr_valid ? fifo_pc[rptr_q] : '0;
    fifo_count  = count_q;
    pop         = instr_valid & instr_ready;
    push        = inflight_q;
    // Slots committed after this edge: buffered + returning read - departing head.
    occupancy   = {1'b0, count_q} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
    issue       = reset_n & fetch_en & ~wr_en & ~redirect & (occupancy < DepthOcc);
  end

  // Memory is never reset so that a program survives reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (issue) begin
      rd_data_q <= mem[pc_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && !redirect && push) begin
      fifo_data[wptr_q] <= rd_data_q;
      fifo_pc[wptr_q]   <= rd_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q       <= ResetPc;
      rd_pc_q    <= '0;
      inflight_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else if (redirect) begin
      pc_q       <= redirect_pc;
      inflight_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q    <= pc_q + 1'b1;
        rd_pc_q <= pc_q;
      end
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_memory.sv
// Scoreboard bench: stimulus queues expected PCs, a negedge monitor checks each delivery.
module tb_instruction_prefetch_memory;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instruction;
  logic [7:0]  instr_pc;
  logic [2:0]  fifo_count;

  instruction_prefetch_memory #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(8),
    .FIFO_DEPTH(4),
    .RESET_PC(0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .fetch_en(fetch_en),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instruction(instruction),
    .instr_pc(instr_pc),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  logic [15:0] model [256];
  int unsigned exp_q [$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, output int cycles);
    cycles = 0;
    instr_ready = 1'b1;
    while (exp_q.size() != 0 && cycles < budget) begin
      tick();
      cycles++;
    end
    instr_ready = 1'b0;
    check("drain_timeout_remaining", exp_q.size(), 0);
  endtask

  task automatic redirect_to(input logic [7:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect    = 1'b0;
  endtask

  task automatic push_range(input int unsigned first, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) exp_q.push_back((first + i) % 256);
  endtask

  // Monitor: delivery order/content, idle zeros, and head stability under back-pressure.
  logic        held = 1'b0;
  logic [15:0] held_instr;
  logic [7:0]  held_pc;
  always @(negedge clk) begin
    int unsigned e;
    if (reset_n) begin
      check("valid_vs_count", instr_valid, (fifo_count != 0));
      if (!instr_valid) begin
        check("idle_instruction", instruction, 0);
        check("idle_pc", instr_pc, 0);
      end
      if (held) begin
        check("held_valid", instr_valid, 1);
        check("held_instruction", instruction, held_instr);
        check("held_pc", instr_pc, held_pc);
      end
      if (instr_valid && instr_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          check("unexpected_delivery_pending", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("deliver_pc", instr_pc, e);
          check("deliver_instr", instruction, model[e]);
        end
      end
    end
    held       = reset_n && !redirect && instr_valid && !instr_ready;
    held_instr = instruction;
    held_pc    = instr_pc;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int a = 0; a < 256; a++) begin
      if (a < 8) model[a] = 16'((a + 1) * 32'h1111);
      else if (a == 255) model[a] = 16'hABCD;
      else model[a] = 16'(32'hC000 | a);
    end
    tick();
    tick();
    for (int a = 0; a < 256; a++) begin
      wr_en   = 1'b1;
      wr_addr = 8'(a);
      wr_data = model[a];
      tick();
    end
    wr_en = 1'b0;
    check("reset_valid", instr_valid, 0);
    check("reset_count", fifo_count, 0);
    check("reset_instruction", instruction, 0);
    check("reset_pc", instr_pc, 0);

    // Basic streaming from RESET_PC.
    fetch_en = 1'b1;
    push_range(0, 8);
    reset_n     = 1'b1;
    instr_ready = 1'b1;
    tick();
    check("r1_valid", instr_valid, 0);
    tick();
    check("r2_valid", instr_valid, 1);
    check("r2_instruction", instruction, 16'h1111);
    check("r2_pc", instr_pc, 0);
    drain(20, cyc);
    check("stream_cycles", cyc, 8);

    // Back-pressure: saturate at depth, then resume without gaps.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("full_count", fifo_count, 4);
    check("full_instruction", instruction, 16'h1111);
    check("full_pc", instr_pc, 0);
    push_range(0, 8);
    drain(20, cyc);
    check("resume_cycles", cyc, 8);

    // Redirect with 3 buffered and a pop offered on the redirect edge.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("pre_redirect_count", fifo_count, 3);
    instr_ready = 1'b1;
    redirect_to(8'h05);
    instr_ready = 1'b0;
    check("e0_valid", instr_valid, 0);
    check("e0_count", fifo_count, 0);
    push_range(5, 5);
    instr_ready = 1'b1;
    tick();
    check("e1_valid", instr_valid, 0);
    tick();
    check("e2_valid", instr_valid, 1);
    check("e2_instruction", instruction, 16'h6666);
    check("e2_pc", instr_pc, 5);
    drain(20, cyc);
    check("redirect_stream_cycles", cyc, 5);

    // PC wrap from 0xFF to 0x00.
    redirect_to(8'hFE);
    push_range(8'hFE, 4);
    drain(20, cyc);

    // Writes during streaming suspend issue only.
    redirect_to(8'h10);
    push_range(8'h10, 16);
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_addr = 8'(8'h40 + i);
      wr_data = 16'(16'h5A00 + i);
      model[8'h40 + i] = 16'(16'h5A00 + i);
      tick();
    end
    wr_en = 1'b0;
    drain(60, cyc);

    // A write to an already-buffered address does not alter the buffered word.
    redirect_to(8'h50);
    for (int i = 0; i < 6; i++) tick();
    check("buffered_count", fifo_count, 4);
    wr_en   = 1'b1;
    wr_addr = 8'h51;
    wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0;
    push_range(8'h50, 4);
    drain(20, cyc);
    model[8'h51] = 16'hBEEF;

    // Redirect and write on the same edge: both take effect.
    wr_en   = 1'b1;
    wr_addr = 8'h30;
    wr_data = 16'h3C3C;
    model[8'h30] = 16'h3C3C;
    redirect_to(8'h30);
    wr_en = 1'b0;
    push_range(8'h30, 2);
    drain(20, cyc);

    // fetch_en low: in-flight read lands, nothing more issues, buffer drains.
    redirect_to(8'h60);
    tick();
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("fetch_off_count", fifo_count, 2);
    push_range(8'h60, 2);
    drain(20, cyc);
    tick();
    check("fetch_off_empty", fifo_count, 0);
    fetch_en = 1'b1;

    // Reset with 2 buffered and one in flight; memory survives.
    redirect_to(8'h20);
    for (int i = 0; i < 3; i++) tick();
    check("pre_reset_count", fifo_count, 2);
    reset_n = 1'b0;
    tick();
    check("mid_reset_valid", instr_valid, 0);
    check("mid_reset_count", fifo_count, 0);
    check("mid_reset_instruction", instruction, 0);
    check("mid_reset_pc", instr_pc, 0);
    reset_n = 1'b1;
    push_range(0, 4);
    drain(20, cyc);

    check("scoreboard_leftover", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_prefetch_memory.md
INSTRUCTION_PREFETCH_MEMORY -- requirements
Module: instruction_prefetch_memory

Interface
REQ-001 Parameter DATA_WIDTH, default 16: instruction word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 8: word address width; memory depth SHALL be 2**ADDR_WIDTH words.
REQ-003 Parameter FIFO_DEPTH, default 4: prefetch buffer entries; power of two, >= 2.
REQ-004 Parameter RESET_PC, default 0: fetch address loaded on reset.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset_n  input  1  reset is synchronous and active-low.
REQ-007 wr_en  input  1  program-load write strobe.
REQ-008 wr_addr  input  ADDR_WIDTH  program-load word address.
REQ-009 wr_data  input  DATA_WIDTH  program-load word.
REQ-010 fetch_en  input  1  enables issue of new sequential reads.
REQ-011 redirect  input  1  flush buffer and restart fetch at redirect_pc.
REQ-012 redirect_pc  input  ADDR_WIDTH  restart address.
REQ-013 instr_valid  output  1  buffer head holds a valid instruction.
REQ-014 instr_ready  input  1  consumer accepts head this cycle.
REQ-015 instruction  output  DATA_WIDTH  head instruction word.
REQ-016 instr_pc  output  ADDR_WIDTH  word address of head instruction.
REQ-017 fifo_count  output  clog2(FIFO_DEPTH)+1  buffered entries, excluding in-flight read.

Function
REQ-018 Memory write SHALL be synchronous: wr_en=1 at an edge stores wr_data at wr_addr.
REQ-019 Memory read SHALL be synchronous with one-cycle latency; data returned is pushed into the FIFO together with its address.
REQ-020 A read SHALL issue in a cycle iff reset_n=1, fetch_en=1, wr_en=0, redirect=0, and fifo_count + inflight - pop < FIFO_DEPTH, where pop = instr_valid & instr_ready.
REQ-021 Each issued read SHALL use the fetch PC, then PC <= PC+1 modulo 2**ADDR_WIDTH (PC 2**ADDR_WIDTH-1 wraps to 0).
REQ-022 At most one read SHALL be in flight; returned data SHALL be pushed on the following edge.
REQ-023 Pop SHALL occur at an edge where instr_valid=1 and instr_ready=1; push and pop in the same edge SHALL leave fifo_count unchanged.
REQ-024 instr_valid SHALL equal (fifo_count != 0); with instr_valid=1 and instr_ready=0, instruction and instr_pc SHALL hold stable.
REQ-025 When fifo_count=0, instruction and instr_pc SHALL drive all-zero.
REQ-026 With fetch_en=1, instr_ready=1, no writes, no redirects: after priming, one instruction SHALL be delivered per cycle at consecutive PCs.
REQ-027 redirect=1 at an edge SHALL: empty FIFO, discard any in-flight read, ignore a simultaneous pop, set PC <= redirect_pc.
REQ-028 After a redirect edge E, instr_valid SHALL be 0 until edge E+2; first instruction from redirect_pc SHALL be valid after E+2 if fetch conditions hold.
REQ-029 wr_en=1 SHALL suspend issue (REQ-020) but SHALL NOT flush FIFO or affect an in-flight read; buffered words already fetched are not updated by later writes.
REQ-030 redirect and wr_en asserted together: both SHALL take effect (write performed, flush and PC load performed).
REQ-031 fetch_en=0 SHALL stop issue only; in-flight read completes and buffer drains normally.

Reset
REQ-032 reset_n=0 at an edge SHALL set PC <= RESET_PC, FIFO empty, in-flight cleared, instr_valid=0, fifo_count=0, instruction=0, instr_pc=0.
REQ-033 Reset SHALL NOT alter memory contents; reset mid-fetch discards in-flight data.
REQ-034 After reset release edge R with fetch_en=1, first instruction (address RESET_PC) SHALL be valid after edge R+2.

Verification
REQ-035 Load words 0x1111..0x8888 at addresses 0..7, release reset, fetch_en=1, ready=1 -> instr_valid from R+2, instructions 0x1111,0x2222,... one per cycle, instr_pc 0,1,2,...
REQ-036 ready=0 after load, FIFO_DEPTH=4 -> fifo_count saturates at 4, no further reads, head 0x1111/pc 0 held stable; ready=1 resumes with no gap or loss.
REQ-037 Redirect to 0x05 while FIFO holds 3 entries and pop asserted -> instr_valid=0 for two edges, then head 0x6666, pc 5; popped entry not counted.
REQ-038 PC at 0xFF with mem[0xFF]=0xABCD, mem[0]=0x1111 -> consecutive outputs 0xABCD pc 0xFF, 0x1111 pc 0x00.
REQ-039 Assert wr_en for 3 cycles during streaming -> no issue in those cycles, buffered entries drain, sequence resumes at next PC with no skipped or duplicated address.
REQ-040 Assert reset_n=0 with 2 entries buffered and one in flight -> next cycle instr_valid=0, fifo_count=0; memory contents unchanged on refetch.
